mips_mem_access_unit: RTL

- Memory-side counterpart to the control decoder: executes the MemRead/MemWrite requests the decoder raises for the datapath.
- Translates each request into a single bus transaction with a waitrequest handshake.
- Handles byte, half and word lane steering for LB/LBU/LH/LHU/LW/SB/SH/SW, and stalls the datapath until the transaction completes.
- Sits between the datapath's memory stage and the data bus.

---
 rtl/mips_pkg.sv | 9 +
 rtl/mips_mem_lane_align.sv | 29 ++
 rtl/mips_mem_access_unit.sv | 110 +++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared types and byte-enable constants for the memory access unit
package mips_pkg;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} mem_size_t;
  typedef enum logic [1:0] {IDLE, REQ, DONE, FAULT} mau_state_t;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;
endpackage

// File: rtl/mips_mem_lane_align.sv
// mips_mem_lane_align: byte-lane steering, alignment check and load extract/extend
module mips_mem_lane_align
  import mips_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        sgn_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        bad_o
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b       = rdata_i[{off_i, 3'b000} +: 8];
    h       = rdata_i[{off_i[1], 4'b0000} +: 16];
    be_o    = size_i == SZ_BYTE ? BE_BYTE0 << off_i :
              size_i == SZ_HALF ? (off_i[1] ? BE_HALF_HI : BE_HALF_LO) :
              size_i == SZ_WORD ? BE_WORD : 4'b0000;
    wdata_o = size_i == SZ_BYTE ? {4{wdata_i[7:0]}} :
              size_i == SZ_HALF ? {2{wdata_i[15:0]}} : wdata_i;
    rdata_o = size_i == SZ_BYTE ? {{24{sgn_i & b[7]}}, b} :
              size_i == SZ_HALF ? {{16{sgn_i & h[15]}}, h} : rdata_i;
    bad_o   = (size_i == 2'd3) | (size_i == SZ_HALF & off_i[0]) | (size_i == SZ_WORD & |off_i);
  end
endmodule

// File: rtl/mips_mem_access_unit.sv
// mips_mem_access_unit: turns MemRead/MemWrite requests into one waitrequest bus transaction
module mips_mem_access_unit
  import mips_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        mem_signed,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err,
  output logic        stall,
  output logic [31:0] bus_address,
  output logic        bus_read,
  output logic        bus_write,
  output logic [3:0]  bus_byteenable,
  output logic [31:0] bus_writedata,
  input  logic        bus_waitrequest,
  input  logic [31:0] bus_readdata
);
  mau_state_t  state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, cnt_q, cnt_d;
  logic [1:0]  size_q, size_d;
  logic        sgn_q, sgn_d, wr_q, wr_d;
  logic        idle, in_req, bad;
  logic [3:0]  be;
  logic [31:0] wd_steer, ld;
  assign idle   = state_q == IDLE;
  assign in_req = state_q == REQ;
  // Live request fields drive the aligner in IDLE (legality), captured ones in REQ (steering/extract).
  mips_mem_lane_align u_align (
    .size_i  (idle ? mem_size : size_q),
    .sgn_i   (idle ? mem_signed : sgn_q),
    .off_i   (idle ? addr[1:0] : addr_q[1:0]),
    .wdata_i (wdata_q),
    .rdata_i (bus_readdata),
    .be_o    (be),
    .wdata_o (wd_steer),
    .rdata_o (ld),
    .bad_o   (bad)
  );
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    wr_d    = wr_q;
    unique case (state_q)
      IDLE: if (mem_read | mem_write) begin
        if (bad | (mem_read & mem_write)) state_d = FAULT;
        else begin
          state_d = REQ;
          addr_d  = addr;
          wdata_d = wdata;
          size_d  = mem_size;
          sgn_d   = mem_signed;
          wr_d    = mem_write;
          cnt_d   = '0;
        end
      end
      REQ: if (!bus_waitrequest) begin
        state_d = DONE;
        rdata_d = wr_q ? '0 : ld;
      end else begin
        cnt_d = cnt_q + 32'd1;
        if (TIMEOUT_CYCLES != 0 && cnt_d == TIMEOUT_CYCLES) state_d = FAULT;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      size_q  <= '0;
      sgn_q   <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      wr_q    <= wr_d;
    end
  end
  assign rdata          = rdata_q;
  assign ack            = state_q == DONE;
  assign err            = state_q == FAULT;
  assign stall          = idle ? (mem_read | mem_write) : in_req;
  assign bus_read       = in_req & ~wr_q;
  assign bus_write      = in_req & wr_q;
  assign bus_address    = in_req ? {addr_q[31:2], 2'b00} : '0;
  assign bus_byteenable = in_req ? be : '0;
  assign bus_writedata  = in_req ? wd_steer : '0;
endmodule
